// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the fetch bus (ibus) and
// the data bus (dbus). One owner at a time; the owner's request is latched
// into a buffer that drives the shared port until the port completes it.
// The single-beat response is routed back to the owner.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   ireq_valid, ireq_addr        fetch request (held until iresp_data_ok)
//   iresp_data_ok, iresp_data    fetch completion pulse + 32-bit word
//   dreq_valid, dreq_addr,       data request (held until dresp_data_ok)
//   dreq_size, dreq_strobe,
//   dreq_data
//   dresp_data_ok, dresp_data    data completion pulse + read data
//   mreq_valid, mreq_addr,       shared-port request, driven from the buffer
//   mreq_size, mreq_strobe,
//   mreq_data
//   mresp_ok, mresp_data         shared-port completion + read data
//
// Build option
//   ARB_ROUND_ROBIN_EN  undefined: dbus priority with an anti-starvation
//                       streak limit (MAX_D_STREAK).
//                       defined: alternate between requesters on contention.
//
// The *_data_ok / *_data responses are combinational from mresp_ok so the
// requester sees completion in the same cycle the port finishes.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_i, grant_d;
  logic   prefer_i;

`ifdef ARB_ROUND_ROBIN_EN
  // 1: the most recent grant went to ibus (reset value)
  logic last_owner_i;
`else
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  logic [STREAK_W-1:0] d_streak;
`endif

  // Arbitration, next state and same-cycle response routing
  always_comb begin
    state_d       = state_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    prefer_i      = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;

`ifdef ARB_ROUND_ROBIN_EN
    prefer_i = ~last_owner_i;
`else
    prefer_i = (d_streak == STREAK_W'(MAX_D_STREAK));
`endif

    case (state_q)
      IDLE: begin
        // prefer_i only matters when both requesters are valid
        if (ireq_valid && (!dreq_valid || prefer_i)) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end else if (dreq_valid) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mresp_ok) begin
          state_d       = IDLE;
          iresp_data_ok = 1'b1;
          // fetch word is the half of the 64-bit beat selected by addr[2]
          iresp_data    = ireq_addr[2] ? mresp_data[2*WORD_W-1:WORD_W]
                                       : mresp_data[WORD_W-1:0];
        end
      end
      BUSY_D: begin
        if (mresp_ok) begin
          state_d       = IDLE;
          dresp_data_ok = 1'b1;
          dresp_data    = mresp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request buffer and shared-port valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mreq_valid  <= 1'b0;
      mreq_addr   <= '0;
      mreq_size   <= '0;
      mreq_strobe <= '0;
      mreq_data   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        mreq_valid  <= 1'b1;
        mreq_addr   <= ireq_addr;
        mreq_size   <= 3'd2;
        mreq_strobe <= 8'h00;
        mreq_data   <= '0;
      end else if (grant_d) begin
        mreq_valid  <= 1'b1;
        mreq_addr   <= dreq_addr;
        mreq_size   <= dreq_size;
        mreq_strobe <= dreq_strobe;
        mreq_data   <= dreq_data;
      end else if ((state_q != IDLE) && mresp_ok) begin
        mreq_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was served last so contention alternates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_i <= 1'b1;
    end else if (grant_i) begin
      last_owner_i <= 1'b1;
    end else if (grant_d) begin
      last_owner_i <= 1'b0;
    end
  end
`else
  // Count dbus grants that made a waiting ibus wait longer; saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_streak <= '0;
    end else if (grant_i) begin
      d_streak <= '0;
    end else if (grant_d && ireq_valid && (d_streak != STREAK_W'(MAX_D_STREAK))) begin
      d_streak <= d_streak + STREAK_W'(1);
    end
  end
`endif

  // Protocol checks: owner must hold its request; no completion while idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!((state_q == BUSY_I) && !ireq_valid));
      assert (!((state_q == BUSY_D) && !dreq_valid));
      assert (!((state_q == IDLE) && mresp_ok));
    end
  end

endmodule
